id_regfile_scoreboard: RTL and testbench
========================================

Name: id_regfile_scoreboard

Overview:
- Next-generation decode-stage register file for the ARM-style 5-stage pipeline.
- Provides NUM_READ combinational read ports with write-back bypass, one write port from WB, and PC-register readout.
- Includes a per-register pending-write scoreboard. Each register has an in-flight counter, incremented at issue and decremented at write-back.
- The scoreboard drives the decode-stage hazard signal, replacing external source/destination comparison.

Parameters:
WORD_SIZE, 32, data width of each register
ADDRESS_SIZE, 4, register address width; 2**ADDRESS_SIZE registers
NUM_READ, 3, number of read ports (Rn, Rm, Rd-for-store)
PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1
PC_REG, 15, register index whose read returns PC_In; storage for it is never written

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
rd_addr  in  NUM_READ*ADDRESS_SIZE  packed read addresses, port i at [i*ADDRESS_SIZE +: ADDRESS_SIZE]
rd_used  in  NUM_READ  port i address is a real source of the decoding instruction
rd_data  out  NUM_READ*WORD_SIZE  packed read data
PC_In  in  WORD_SIZE  PC value returned for reads of PC_REG
issue_en  in  1  decoding instruction wants to advance to EXE this cycle
issue_wb_en  in  1  decoding instruction writes a register
issue_dest  in  ADDRESS_SIZE  destination of decoding instruction
writeBackEn  in  1  WB stage write strobe
Dest_wb  in  ADDRESS_SIZE  WB destination
Result_WB  in  WORD_SIZE  WB data
hazard  out  1  stall decode; issue this cycle is not accepted
issue_ack  out  1  issue_en & ~hazard
busy_vec  out  2**ADDRESS_SIZE  bit r = (pend[r] != 0)
sb_err  out  1  sticky; write-back seen to a register with pend == 0

Behaviour:
- Reset: on rising CLK with RST=1, all registers are cleared to 0, all pend counters to 0, and sb_err to 0. Issue and write-back that cycle are ignored. Combinational outputs then follow: rd_data = 0 (or PC_In for PC_REG), hazard = 0 unless a saturated-dest condition applies, busy_vec = 0.
- Read port i, combinational:
  - if rd_addr_i == PC_REG, return PC_In;
  - else if writeBackEn & Dest_wb == rd_addr_i, return Result_WB (bypass, same cycle);
  - else return regs[rd_addr_i].
  - Unused ports (rd_used_i=0) still return data.
- Write: on rising CLK with writeBackEn and Dest_wb != PC_REG, regs[Dest_wb] <= Result_WB. Writes to PC_REG do not update storage but still update the scoreboard.
- Source hazard for port i: rd_used_i & rd_addr_i != PC_REG & (pend[a] >= 2, or pend[a] == 1 and no write-back to a this cycle).
  - pend == 1 with a same-cycle write-back is resolved by the bypass.
- Dest hazard: issue_wb_en & pend[issue_dest] == 2**PEND_W-1, after accounting for a same-cycle write-back decrement to the same register.
- hazard = issue_en & (any source hazard | dest hazard). hazard is 0 when issue_en = 0.
- Counter update per register r at each edge, applied together:
  - inc = issue_ack & issue_wb_en & issue_dest == r
  - dec = writeBackEn & Dest_wb == r & pend[r] != 0
  - inc & dec: value unchanged
  - inc only: +1
  - dec only: -1
  - Counters never wrap; saturation is prevented by the dest hazard.
- Write-back with pend[Dest_wb] == 0: the data is still written, the counter stays 0, and sb_err is set; sb_err stays set until RST.
- Latency: read and hazard are 0 cycles (combinational). Counter and storage effects are visible the cycle after the edge.
- Reset while instructions are in flight clears the scoreboard. Their later write-backs set sb_err, which is the required, intended behaviour; the pipeline flushes on reset.

Test Plan:
- Reset, then read all ports at addr 3: rd_data = 0. With rd_addr=15 and PC_In=0x100, port returns 0x100. busy_vec = 0, sb_err = 0.
- Issue ADD dest R3 (issue_en=1, issue_wb_en=1); next cycle decode uses R3 on port 0: hazard=1 and busy_vec[3]=1. Write-back R3=0xDEAD with writeBackEn=1 that same cycle: hazard=0, rd_data port0=0xDEAD (bypass). Following cycle pend[3]=0.
- Issue three writes to R5 in consecutive cycles (PEND_W=2): pend reaches 3, and a fourth issue to R5 gives hazard=1, issue_ack=0. Same fourth attempt with a concurrent write-back to R5 gives hazard=0, pend stays 3.
- pend[7]=2 with write-back to R7 and a decode reading R7: hazard=1 despite the bypass. Next cycle pend=1.
- Write-back to R9 with pend[9]=0: regs[9] updated, sb_err=1, held after 10 idle cycles, cleared only by RST.
- Assert RST while pend[2]=1 and pend[4]=2: after the edge all counters are 0 and all registers 0. A later write-back to R4 sets sb_err=1.

Source files
------------

// File: rtl/id_regfile_scoreboard.sv
// id_regfile_scoreboard: decode-stage register file with write-back bypass and a per-register pending-write scoreboard
//   CLK, RST      clock, synchronous active-high reset
//   rd_addr/used  packed read addresses and "is a real source" flags
//   rd_data       packed combinational read data (PC_In for PC_REG, bypassed WB data on match)
//   PC_In         value returned for reads of PC_REG
//   issue_*       decoding instruction: wants to issue, writes a register, its destination
//   writeBackEn, Dest_wb, Result_WB   write-back port
//   hazard        stall decode, issue_ack = issue_en & ~hazard
//   busy_vec      per-register "write in flight" flags
//   sb_err        sticky: write-back arrived for a register with nothing pending
module id_regfile_scoreboard #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 4,
    parameter int NUM_READ     = 3,
    parameter int PEND_W       = 2,
    parameter int PC_REG       = 15
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_READ*ADDRESS_SIZE-1:0] rd_addr,
    input  logic [NUM_READ-1:0]              rd_used,
    output logic [NUM_READ*WORD_SIZE-1:0]    rd_data,
    input  logic [WORD_SIZE-1:0]             PC_In,
    input  logic                             issue_en,
    input  logic                             issue_wb_en,
    input  logic [ADDRESS_SIZE-1:0]          issue_dest,
    input  logic                             writeBackEn,
    input  logic [ADDRESS_SIZE-1:0]          Dest_wb,
    input  logic [WORD_SIZE-1:0]             Result_WB,
    output logic                             hazard,
    output logic                             issue_ack,
    output logic [2**ADDRESS_SIZE-1:0]       busy_vec,
    output logic                             sb_err
);
    localparam int NREG = 2**ADDRESS_SIZE;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [ADDRESS_SIZE-1:0] PC_A = ADDRESS_SIZE'(PC_REG);

    logic [WORD_SIZE-1:0] regs [NREG];
    logic [PEND_W-1:0]    pend [NREG];
    logic [NUM_READ-1:0]  src_haz;
    logic [NREG-1:0]      inc;
    logic [NREG-1:0]      dec;
    logic                 dest_wb_hit;
    logic [PEND_W-1:0]    dest_pend;
    logic                 dest_haz;

    genvar i;
    for (i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_SIZE-1:0] a;
        logic                    wb_hit;
        assign a      = rd_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign wb_hit = writeBackEn && Dest_wb == a;
        assign rd_data[i*WORD_SIZE +: WORD_SIZE] = a == PC_A ? PC_In : wb_hit ? Result_WB : regs[a];
        // A single outstanding write landing this cycle is covered by the bypass;
        // with two or more outstanding, the bypassed value is not the youngest one.
        assign src_haz[i] = rd_used[i] && a != PC_A &&
                            (pend[a] > PEND_ONE || (pend[a] == PEND_ONE && !wb_hit));
    end

    // A same-cycle write-back to the destination frees one slot before the issue is counted.
    assign dest_wb_hit = writeBackEn && Dest_wb == issue_dest && pend[issue_dest] != '0;
    assign dest_pend   = pend[issue_dest] - PEND_W'(dest_wb_hit);
    assign dest_haz    = issue_wb_en && dest_pend == PEND_MAX;
    assign hazard      = issue_en && (|src_haz || dest_haz);
    assign issue_ack   = issue_en && !hazard;

    genvar r;
    for (r = 0; r < NREG; r++) begin : g_sb
        assign inc[r]      = issue_ack && issue_wb_en && issue_dest == ADDRESS_SIZE'(r);
        assign dec[r]      = writeBackEn && Dest_wb == ADDRESS_SIZE'(r) && pend[r] != '0;
        assign busy_vec[r] = pend[r] != '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
                pend[k] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            // PC_REG reads always come from PC_In, so its storage is left untouched.
            if (writeBackEn && Dest_wb != PC_A) regs[Dest_wb] <= Result_WB;
            if (writeBackEn && pend[Dest_wb] == '0) sb_err <= 1'b1;
            for (int k = 0; k < NREG; k++)
                pend[k] <= pend[k] + PEND_W'(inc[k]) - PEND_W'(dec[k]);
        end
    end
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// tb_id_regfile_scoreboard: scoreboard-driven check of the decode register file and pending-write tracking
module tb_id_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rd_addr;
    logic [2:0]  rd_used;
    logic [95:0] rd_data;
    logic [31:0] pc_in;
    logic        issue_en, issue_wb_en;
    logic [3:0]  issue_dest;
    logic        wb_en;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    logic        hazard, issue_ack, sb_err;
    logic [15:0] busy_vec;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    localparam int RD0 = 0, RD1 = 1, RD2 = 2, HAZ = 3, ACK = 4, BUSY = 5, ERR = 6;

    id_regfile_scoreboard dut (
        .CLK(clk), .RST(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
        .PC_In(pc_in), .issue_en(issue_en), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .writeBackEn(wb_en), .Dest_wb(dest_wb), .Result_WB(result_wb),
        .hazard(hazard), .issue_ack(issue_ack), .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int s);
        case (s)
            RD0:     return rd_data[31:0];
            RD1:     return rd_data[63:32];
            RD2:     return rd_data[95:64];
            HAZ:     return {31'd0, hazard};
            ACK:     return {31'd0, issue_ack};
            BUSY:    return {16'd0, busy_vec};
            default: return {31'd0, sb_err};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        q.push_back('{tag, sel, val});
    endtask

    // Compare everything queued for this cycle's inputs, then let the edge commit them.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, obs(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rd_addr = '0; rd_used = '0; issue_en = 0; issue_wb_en = 0; issue_dest = '0;
        wb_en = 0; dest_wb = '0; result_wb = '0;
    endtask

    task automatic issue(input logic [3:0] d);
        idle(); issue_en = 1; issue_wb_en = 1; issue_dest = d;
    endtask

    initial begin
        idle(); rst = 1; pc_in = 32'h100;
        @(posedge clk); #1;
        idle();
        rd_addr = {4'd3, 4'd15, 4'd3};
        expect_val("rst_rd0", RD0, 0); expect_val("pc_rd1", RD1, 32'h100);
        expect_val("rst_rd2", RD2, 0); expect_val("rst_busy", BUSY, 0);
        expect_val("rst_err", ERR, 0); expect_val("rst_haz", HAZ, 0);
        tick();

        issue(3);
        expect_val("r3_iss_haz", HAZ, 0); expect_val("r3_iss_ack", ACK, 1);
        tick();
        idle(); issue_en = 1; rd_used = 3'b001; rd_addr = {4'd0, 4'd0, 4'd3};
        expect_val("r3_src_haz", HAZ, 1); expect_val("r3_src_ack", ACK, 0);
        expect_val("r3_busy", BUSY, 16'h0008);
        tick();
        idle(); issue_en = 1; rd_used = 3'b001; rd_addr = {4'd0, 4'd0, 4'd3};
        wb_en = 1; dest_wb = 3; result_wb = 32'hDEAD;
        expect_val("r3_byp_haz", HAZ, 0); expect_val("r3_byp_ack", ACK, 1);
        expect_val("r3_byp_rd0", RD0, 32'hDEAD);
        tick();
        idle(); rd_addr = {4'd0, 4'd0, 4'd3};
        expect_val("r3_busy_clr", BUSY, 0); expect_val("r3_stored", RD0, 32'hDEAD);
        expect_val("r3_err", ERR, 0); expect_val("noiss_ack", ACK, 0);
        tick();

        for (int k = 0; k < 3; k++) begin
            issue(5);
            expect_val($sformatf("r5_iss%0d_ack", k), ACK, 1);
            tick();
        end
        issue(5);
        expect_val("r5_sat_haz", HAZ, 1); expect_val("r5_sat_ack", ACK, 0);
        expect_val("r5_busy", BUSY, 16'h0020);
        tick();
        issue(5); wb_en = 1; dest_wb = 5; result_wb = 32'h55;
        expect_val("r5_satwb_haz", HAZ, 0); expect_val("r5_satwb_ack", ACK, 1);
        tick();
        issue(5);
        expect_val("r5_still3_haz", HAZ, 1);
        tick();

        issue(7); tick();
        issue(7); tick();
        idle(); issue_en = 1; rd_used = 3'b010; rd_addr = {4'd0, 4'd7, 4'd0};
        wb_en = 1; dest_wb = 7; result_wb = 32'h77;
        expect_val("r7_p2_haz", HAZ, 1); expect_val("r7_p2_rd1", RD1, 32'h77);
        tick();
        idle(); issue_en = 1; rd_used = 3'b010; rd_addr = {4'd0, 4'd7, 4'd0};
        expect_val("r7_p1_haz", HAZ, 1); expect_val("r7_p1_rd1", RD1, 32'h77);
        tick();
        idle(); issue_en = 1; rd_used = 3'b010; rd_addr = {4'd0, 4'd7, 4'd0};
        wb_en = 1; dest_wb = 7; result_wb = 32'h78;
        expect_val("r7_p1wb_haz", HAZ, 0); expect_val("r7_p1wb_ack", ACK, 1);
        tick();
        idle();
        expect_val("r7_busy", BUSY, 16'h0020);
        tick();

        idle(); rd_addr = {4'd9, 4'd0, 4'd0}; wb_en = 1; dest_wb = 9; result_wb = 32'h99;
        expect_val("r9_byp", RD2, 32'h99); expect_val("r9_err_pre", ERR, 0);
        tick();
        idle(); rd_addr = {4'd9, 4'd0, 4'd0};
        expect_val("r9_stored", RD2, 32'h99); expect_val("r9_err", ERR, 1);
        tick();
        idle();
        repeat (10) tick();
        expect_val("r9_err_held", ERR, 1);
        tick();

        issue(2); tick();
        issue(4); tick();
        issue(4); tick();
        idle();
        expect_val("pre_rst_busy", BUSY, 16'h0034);
        tick();
        idle(); rst = 1; issue(6); rst = 1;
        tick();
        idle(); rd_addr = {4'd7, 4'd9, 4'd3};
        expect_val("rst2_busy", BUSY, 0); expect_val("rst2_err", ERR, 0);
        expect_val("rst2_rd0", RD0, 0); expect_val("rst2_rd1", RD1, 0);
        expect_val("rst2_rd2", RD2, 0);
        tick();
        idle(); wb_en = 1; dest_wb = 4; result_wb = 32'h44;
        expect_val("late_wb_err_pre", ERR, 0);
        tick();
        idle(); rd_addr = {4'd0, 4'd0, 4'd4};
        expect_val("late_wb_err", ERR, 1); expect_val("late_wb_rd0", RD0, 32'h44);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
